// File: rtl/alu_pkg.sv
// Shared ALU definitions: 4-bit ALU codes, decode classes, R-type funct values and issue-stage states.
// Used by the issue stage and by the ALU itself.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_NAND  = 4'd2;
    localparam logic [3:0] ALU_NOR   = 4'd3;
    localparam logic [3:0] ALU_ADDU  = 4'd4;
    localparam logic [3:0] ALU_SUBU  = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;
    localparam logic [3:0] ALU_EQUAL = 4'd7;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_RTYPE = 3'd2;
    localparam logic [2:0] OP_AND   = 3'd3;
    localparam logic [2:0] OP_OR    = 3'd4;
    localparam logic [2:0] OP_SLT   = 3'd5;
    localparam logic [2:0] OP_EQUAL = 3'd6;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NAND = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Encoding is {skid valid, main valid}
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } issue_state_t;

endpackage

// File: rtl/alu_decode.sv
// Decode {aluop, funct} into the 4-bit ALU code plus an illegal flag.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Illegal encodings produce ADDU so a non-trapping build issues them harmlessly.
module alu_decode
    import alu_pkg::*;
(
    input  logic [2:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl    = ALU_ADDU;
        illegal = 1'b0;
        case (aluop)
            OP_ADD:   ctrl = ALU_ADDU;
            OP_SUB:   ctrl = ALU_SUBU;
            OP_AND:   ctrl = ALU_AND;
            OP_OR:    ctrl = ALU_OR;
            OP_SLT:   ctrl = ALU_SLT;
            OP_EQUAL: ctrl = ALU_EQUAL;
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: ctrl = ALU_ADDU;
                    FN_SUB, FN_SUBU: ctrl = ALU_SUBU;
                    FN_AND:          ctrl = ALU_AND;
                    FN_OR:           ctrl = ALU_OR;
                    FN_NAND:         ctrl = ALU_NAND;
                    FN_NOR:          ctrl = ALU_NOR;
                    FN_SLT:          ctrl = ALU_SLT;
                    default:         illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes aluop/funct and presents registered operands through a main register plus one-entry skid.
// Latency: 1 cycle when empty or draining. Backpressure: in_ready_o = !skid valid, registered, no path from out_ready_i.
// ALU_ISSUE_ILLEGAL_TRAP_EN: drop illegal decodes and raise sticky illegal_o; otherwise they issue as ADDU.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [2:0]    aluop_i,
    input  logic [5:0]    funct_i,
    input  logic [DW-1:0] src1_i,
    input  logic [DW-1:0] src2_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [3:0]    alu_ctrl_o,
    output logic [DW-1:0] alu_src1_o,
    output logic [DW-1:0] alu_src2_o,
    output logic          illegal_o
);

    issue_state_t  state_q, state_d;
    logic [3:0]    dec_ctrl;
    logic          dec_illegal;
    logic          in_xfer, take, out_xfer;
    logic          m_load, m_from_s, s_load;
    logic [3:0]    s_ctrl;
    logic [DW-1:0] s_src1, s_src2;

    alu_decode u_decode (
        .aluop   (aluop_i),
        .funct   (funct_i),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    assign in_ready_o  = ~state_q[1];
    assign out_valid_o = state_q[0];
    assign in_xfer     = in_valid_i & in_ready_o;
    assign out_xfer    = out_valid_o & out_ready_i;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    // Illegal ops are still handshaken upstream but never enter storage
    assign take = in_xfer & ~dec_illegal;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            illegal_o <= 1'b0;
        else if (in_xfer && dec_illegal)
            illegal_o <= 1'b1;
    end
`else
    logic unused_illegal;
    assign unused_illegal = dec_illegal;
    assign take           = in_xfer;
    assign illegal_o      = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        m_load   = 1'b0;
        m_from_s = 1'b0;
        s_load   = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (take) begin
                    m_load  = 1'b1;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (take && out_xfer) begin
                    m_load = 1'b1;
                end else if (take) begin
                    s_load  = 1'b1;
                    state_d = ST_FULL;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    m_from_s = 1'b1;
                    state_d  = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= ST_EMPTY;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alu_ctrl_o <= ALU_ADDU;
            alu_src1_o <= '0;
            alu_src2_o <= '0;
            s_ctrl     <= ALU_ADDU;
            s_src1     <= '0;
            s_src2     <= '0;
        end else begin
            if (m_from_s) begin
                alu_ctrl_o <= s_ctrl;
                alu_src1_o <= s_src1;
                alu_src2_o <= s_src2;
            end else if (m_load) begin
                alu_ctrl_o <= dec_ctrl;
                alu_src1_o <= src1_i;
                alu_src2_o <= src2_i;
            end
            if (s_load) begin
                s_ctrl <= dec_ctrl;
                s_src1 <= src1_i;
                s_src2 <= src2_i;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed decode, backpressure, illegal, reset and random valid/ready traffic.
`timescale 1ns/1ps
module tb_alu_issue;
    import alu_pkg::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    aluop = '0;
    logic [5:0]    funct = '0;
    logic [DW-1:0] src1 = '0, src2 = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    alu_ctrl;
    logic [DW-1:0] alu_src1, alu_src2;
    logic          illegal;

    alu_issue #(.DW(DW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .aluop_i     (aluop),
        .funct_i     (funct),
        .src1_i      (src1),
        .src2_i      (src2),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .alu_ctrl_o  (alu_ctrl),
        .alu_src1_o  (alu_src1),
        .alu_src2_o  (alu_src2),
        .illegal_o   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    c;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } exp_t;

    exp_t sbq[$];
    int   xcyc[$];
    exp_t mon_e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   done = 1'b0;

    // Hand-computed decode table for the random phase: {aluop, funct, expected ctrl}
    localparam logic [2:0] ROP [15] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd2, 3'd2,
                                        3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
    localparam logic [5:0] RFN [15] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h20, 6'h21,
                                        6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
    localparam logic [3:0] RCT [15] = '{4'd4, 4'd5, 4'd0, 4'd1, 4'd6, 4'd7, 4'd4, 4'd4,
                                        4'd5, 4'd5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd6};

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every output transfer pops the oldest expected operation
    always @(negedge clk) begin
        cyc++;
        if (!rst && out_valid && out_ready) begin
            xcyc.push_back(cyc);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got ctrl=%0h src1=%0h with nothing expected", alu_ctrl, alu_src1);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_ctrl", {28'd0, alu_ctrl}, {28'd0, mon_e.c});
                chk("sb_src1", alu_src1, mon_e.a);
                chk("sb_src2", alu_src2, mon_e.b);
            end
        end
    end

    // Called at posedge+1; holds the op until accepted, then drops in_valid one edge later
    task automatic push(input logic [2:0] op, input logic [5:0] fn, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [3:0] ec, input bit issue);
        int n = 0;
        in_valid = 1'b1;
        aluop = op;
        funct = fn;
        src1 = a;
        src2 = b;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL push_timeout: in_ready stuck at %0b, required 1", in_ready);
        end else if (issue) begin
            sbq.push_back(exp_t'{ec, a, b});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d ops pending, required 0", sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_ctrl", {28'd0, alu_ctrl}, 32'd4);
        chk("rst_src1", alu_src1, 32'd0);
        chk("rst_src2", alu_src2, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // out_ready toggling while empty must not produce anything
        repeat (3) begin
            out_ready = ~out_ready;
            @(posedge clk);
            #1;
        end
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

        // R-type SUB: one-cycle latency
        out_ready = 1'b1;
        push(3'd2, 6'h22, 32'd5, 32'd3, 4'd5, 1'b1);
        chk("rtype_valid", {31'd0, out_valid}, 32'd1);
        chk("rtype_ctrl", {28'd0, alu_ctrl}, 32'd5);
        drain();

        // Class sweep back-to-back: no bubbles
        xcyc.delete();
        push(3'd0, 6'h00, 32'd10, 32'd11, 4'd4, 1'b1);
        push(3'd1, 6'h00, 32'd12, 32'd13, 4'd5, 1'b1);
        push(3'd3, 6'h00, 32'd14, 32'd15, 4'd0, 1'b1);
        push(3'd4, 6'h00, 32'd16, 32'd17, 4'd1, 1'b1);
        push(3'd5, 6'h00, 32'd18, 32'd19, 4'd6, 1'b1);
        push(3'd6, 6'h00, 32'd20, 32'd21, 4'd7, 1'b1);
        drain();
        chk("sweep_count", xcyc.size(), 32'd6);
        for (int i = 1; i < xcyc.size(); i++)
            chk("sweep_gap", xcyc[i] - xcyc[i-1], 32'd1);

        // Backpressure: A then B, stage fills, outputs hold A
        out_ready = 1'b0;
        push(3'd0, 6'h00, 32'hA1, 32'hA2, 4'd4, 1'b1);
        push(3'd2, 6'h27, 32'hB1, 32'hB2, 4'd3, 1'b1);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_src1", alu_src1, 32'hA1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_stable_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_stable_ctrl", {28'd0, alu_ctrl}, 32'd4);
        chk("bp_stable_src2", alu_src2, 32'hA2);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("full_drain_ready", {31'd0, in_ready}, 32'd1);
        chk("full_drain_src1", alu_src1, 32'hB1);
        drain();
        chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);

        // Illegal R-type funct
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        push(3'd2, 6'h3F, 32'h77, 32'h88, 4'd4, 1'b0);
        chk("ill_no_issue", {31'd0, out_valid}, 32'd0);
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        push(3'd0, 6'h00, 32'h1, 32'h2, 4'd4, 1'b1);
        drain();
        chk("ill_sticky", {31'd0, illegal}, 32'd1);
`else
        push(3'd2, 6'h3F, 32'h77, 32'h88, 4'd4, 1'b1);
        chk("ill_issue_valid", {31'd0, out_valid}, 32'd1);
        drain();
        chk("ill_flag_zero", {31'd0, illegal}, 32'd0);
`endif

        // Reset while FULL: everything in flight is dropped
        out_ready = 1'b0;
        push(3'd3, 6'h00, 32'hC1, 32'hC2, 4'd0, 1'b1);
        push(3'd4, 6'h00, 32'hD1, 32'hD2, 4'd1, 1'b1);
        chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        sbq.delete();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_ctrl", {28'd0, alu_ctrl}, 32'd4);
        chk("mid_rst_src1", alu_src1, 32'd0);
        chk("mid_rst_illegal", {31'd0, illegal}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        xcyc.delete();
        push(3'd5, 6'h00, 32'hE1, 32'hE2, 4'd6, 1'b1);
        drain();
        chk("post_rst_count", xcyc.size(), 32'd1);

        // Random valid/ready traffic
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    int k;
                    k = $urandom_range(0, 14);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    push(ROP[k], RFN[k], $urandom, $urandom, RCT[k], 1'b1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("final_empty", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
